// File: rtl/block_interleaver.sv
// -----------------------------------------------------------------------------
// block_interleaver
//   802.11a DATA-field block interleaver for the transmit chain. Coded bits
//   arrive serially, are scattered into one of two symbol banks at their
//   interleaved position, and are read back sequentially toward the mapper.
//   The two banks run ping-pong, so writing symbol n+1 overlaps reading
//   symbol n.
//
// Ports
//   Clock       system clock
//   Reset       asynchronous, active-high reset
//   Input       coded bit
//   InValid     Input carries a valid coded bit this cycle
//   Mode        00 BPSK (48), 01 QPSK (96), 10 16-QAM (192), 11 64-QAM (288)
//   Output      interleaved bit (INITIAL_OUT while OutValid is low)
//   OutValid    Output valid this cycle
//   SymbolStart high with output index 0 of each symbol
//   Busy        a bank is full or a symbol is partially written
// -----------------------------------------------------------------------------
module block_interleaver #(
   parameter int   MAX_NCBPS   = 288,
   parameter logic INITIAL_OUT = 1'b0
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Input,
   input  logic       InValid,
   input  logic [1:0] Mode,
   output logic       Output,
   output logic       OutValid,
   output logic       SymbolStart,
   output logic       Busy
);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   // Coded bits per OFDM symbol for a given modulation.
   function automatic logic [8:0] ncbps(input logic [1:0] m);
      case (m)
         2'b00:   return 9'd48;
         2'b01:   return 9'd96;
         2'b10:   return 9'd192;
         default: return 9'd288;
      endcase
   endfunction

   // Quotient and remainder of v/3 for v <= 17 by compare-and-subtract.
   function automatic logic [4:0] div_mod3(input logic [4:0] v);
      logic [4:0] t;
      logic [2:0] q;
      t = v;
      q = 3'd0;
      if (t >= 5'd9) begin t = t - 5'd9; q = 3'd3;      end
      if (t >= 5'd6) begin t = t - 5'd6; q = q + 3'd2; end
      if (t >= 5'd3) begin t = t - 5'd3; q = q + 3'd1; end
      return {q, t[1:0]};
   endfunction

   // Storage and shared bank state.
   logic       r_mem [2][MAX_NCBPS];
   logic [1:0] r_mode [2];
   logic [1:0] r_full;

   // Write side.
   logic [8:0] r_k;
   logic [3:0] r_r;
   logic [4:0] r_c;
   logic       r_wb;

   // Read side.
   state_t     r_state;
   logic       r_rb;
   logic [8:0] r_addr;

   logic [1:0] w_mode;
   logic       w_stall;
   logic       w_wr_en;
   logic       w_last;
   logic       w_wr_last;
   logic       w_rd_done;
   logic [8:0] w_r9;
   logic [8:0] w_c9;
   logic [8:0] w_i;
   logic [8:0] w_j;
   logic [4:0] w_cdm;
   logic [4:0] w_rdm;
   logic [2:0] w_d;

   // Mode is taken live on the k=0 write and from the bank's stored copy after.
   assign w_mode    = (r_k == 9'd0) ? Mode : r_mode[r_wb];
   // Starting a symbol on a bank that is still unread would overwrite it.
   assign w_stall   = (r_k == 9'd0) && r_full[r_wb];
   assign w_wr_en   = InValid && !w_stall;
   assign w_last    = (r_k == ncbps(w_mode) - 9'd1);
   assign w_wr_last = w_wr_en && w_last;
   assign w_rd_done = (r_state == S_STREAM) &&
                      (r_addr == ncbps(r_mode[r_rb]) - 9'd1);

   assign w_r9  = {5'd0, r_r};
   assign w_c9  = {4'd0, r_c};
   assign w_cdm = div_mod3(r_c);
   assign w_rdm = div_mod3({1'b0, r_r});

   // Write address j. Since i = (N_CBPS/16)*r + c, the second permutation
   // reduces to functions of r and c alone: for s=2 the low bit flips by r[0],
   // and for s=3 (N_CBPS/16 = 18) floor(i/3) = 6r + floor(c/3) and
   // (i - r) mod 3 = (c - r) mod 3.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_i = 9'd0;
      w_j = 9'd0;
      w_d = 3'd0;
      case (w_mode)
         2'b00: w_j = w_r9 * 9'd3 + w_c9;
         2'b01: w_j = w_r9 * 9'd6 + w_c9;
         2'b10: begin
            w_i = w_r9 * 9'd12 + w_c9;
            w_j = {w_i[8:1], w_i[0] ^ r_r[0]};
         end
         default: begin
            w_d = {1'b0, w_cdm[1:0]} + 3'd3 - {1'b0, w_rdm[1:0]};
            if (w_d >= 3'd3) w_d = w_d - 3'd3;
            w_j = w_r9 * 9'd18 + {6'd0, w_cdm[4:2]} * 9'd3 + {7'd0, w_d[1:0]};
         end
      endcase
   end

   // NOTE: bank contents carry no reset; validity is tracked by r_full, so
   // the array stays plain storage.
   always_ff @(posedge Clock) begin
      if (w_wr_en) r_mem[r_wb][w_j] <= Input;
   end

   // Write counters: k advances only on accepted bits, wraps at N_CBPS-1.
   // NOTE: state registers use non-blocking assignments so every block sees
   // the pre-edge values regardless of evaluation order.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_k       <= 9'd0;
         r_r       <= 4'd0;
         r_c       <= 5'd0;
         r_wb      <= 1'b0;
         r_mode[0] <= 2'b00;
         r_mode[1] <= 2'b00;
      end else if (w_wr_en) begin
         if (r_k == 9'd0) r_mode[r_wb] <= Mode;
         if (w_last) begin
            r_k  <= 9'd0;
            r_r  <= 4'd0;
            r_c  <= 5'd0;
            r_wb <= ~r_wb;
         end else begin
            r_k <= r_k + 9'd1;
            r_r <= r_r + 4'd1;
            if (r_r == 4'd15) r_c <= r_c + 5'd1;
         end
      end
   end

   // Full flags: the writer's set takes priority over the reader's clear.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_full <= 2'b00;
      end else begin
         if (w_wr_last && !r_wb)      r_full[0] <= 1'b1;
         else if (w_rd_done && !r_rb) r_full[0] <= 1'b0;
         if (w_wr_last && r_wb)       r_full[1] <= 1'b1;
         else if (w_rd_done && r_rb)  r_full[1] <= 1'b0;
      end
   end

   // Reader. IDLE already emits index 0 when it finds a full bank, which
   // keeps latency at one cycle and makes back-to-back symbols gapless even
   // when the next bank fills on the same edge the current one drains.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_rb        <= 1'b0;
         r_addr      <= 9'd0;
         Output      <= INITIAL_OUT;
         OutValid    <= 1'b0;
         SymbolStart <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_full[r_rb]) begin
                  Output      <= r_mem[r_rb][0];
                  OutValid    <= 1'b1;
                  SymbolStart <= 1'b1;
                  r_addr      <= 9'd1;
                  r_state     <= S_STREAM;
               end else begin
                  Output      <= INITIAL_OUT;
                  OutValid    <= 1'b0;
                  SymbolStart <= 1'b0;
               end
            end
            default: begin
               Output      <= r_mem[r_rb][r_addr];
               OutValid    <= 1'b1;
               SymbolStart <= (r_addr == 9'd0);
               if (w_rd_done) begin
                  r_rb   <= ~r_rb;
                  r_addr <= 9'd0;
                  if (!r_full[~r_rb]) r_state <= S_IDLE;
               end else begin
                  r_addr <= r_addr + 9'd1;
               end
            end
         endcase
      end
   end

   assign Busy = r_full[0] | r_full[1] | (r_k != 9'd0);

   // Dropping a bit here means an illegal Mode sequence reached the writer.
   a_no_stall_drop: assert property (@(posedge Clock) disable iff (Reset)
      !(InValid && w_stall));

endmodule

// File: tb/tb_block_interleaver.sv
// -----------------------------------------------------------------------------
// tb_block_interleaver
//   Randomized self-checking bench. A reference model applies the interleaver
//   formulas with plain integer arithmetic and queues expected output bits;
//   a monitor compares every valid output bit, SymbolStart alignment and the
//   idle behaviour between symbols.
// -----------------------------------------------------------------------------
module tb_block_interleaver;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Input = 1'b0;
   logic       InValid = 1'b0;
   logic [1:0] Mode = 2'b00;
   logic       Output;
   logic       OutValid;
   logic       SymbolStart;
   logic       Busy;

   block_interleaver #(.MAX_NCBPS(288), .INITIAL_OUT(1'b0)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Input       (Input),
      .InValid     (InValid),
      .Mode        (Mode),
      .Output      (Output),
      .OutValid    (OutValid),
      .SymbolStart (SymbolStart),
      .Busy        (Busy)
   );

   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   logic         exp_q [$];
   int           len_q [$];
   int           idx = 0;
   int           run_len = 0;
   int           last_run = 0;
   int           valid_cnt = 0;
   logic [287:0] cap = '0;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int n_cbps(input logic [1:0] m);
      case (m)
         2'b00:   return 48;
         2'b01:   return 96;
         2'b10:   return 192;
         default: return 288;
      endcase
   endfunction

   function automatic int n_bpsc(input logic [1:0] m);
      case (m)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 6;
      endcase
   endfunction

   // Reference permutation: output position j receives input bit k.
   task automatic model_push(input logic [1:0] m, input logic [287:0] d);
      int n, s, r, c, i, j;
      logic [287:0] o;
      n = n_cbps(m);
      s = n_bpsc(m) / 2;
      if (s < 1) s = 1;
      o = '0;
      for (int k = 0; k < n; k++) begin
         r = k % 16;
         c = k / 16;
         i = (n / 16) * r + c;
         j = s * (i / s) + (i + n - r) % s;
         o[j] = d[k];
      end
      for (int a = 0; a < n; a++) exp_q.push_back(o[a]);
      len_q.push_back(n);
   endtask

   // Drives one symbol. gap=1 inserts an idle cycle before every bit.
   // abort_at >= 0 stops after that many bits and queues nothing.
   task automatic send_symbol(input logic [1:0] m, input logic [287:0] d,
                              input bit gap, input int abort_at);
      int n, stop;
      n = n_cbps(m);
      stop = (abort_at >= 0) ? abort_at : n;
      for (int k = 0; k < stop; k++) begin
         if (gap) begin
            InValid = 1'b0;
            Input   = 1'($urandom);
            Mode    = 2'($urandom);
            @(posedge Clock); #1;
         end
         InValid = 1'b1;
         Input   = d[k];
         // Mode only matters on k=0; scramble it elsewhere.
         Mode    = (k == 0) ? m : 2'($urandom);
         @(posedge Clock); #1;
      end
      InValid = 1'b0;
      if (abort_at < 0) model_push(m, d);
   endtask

   function automatic logic [287:0] rand_bits();
      logic [287:0] v;
      for (int i = 0; i < 288; i++) v[i] = 1'($urandom);
      return v;
   endfunction

   function automatic logic [287:0] one_hot(input int k);
      logic [287:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Position of the single 1 in the last captured symbol, -1 otherwise.
   function automatic int onehot_pos(input int n);
      int cnt, pos;
      cnt = 0;
      pos = -1;
      for (int a = 0; a < n; a++)
         if (cap[a]) begin cnt++; pos = a; end
      return (cnt == 1) ? pos : -1;
   endfunction

   task automatic wait_drain(input int budget);
      int n;
      bit done;
      n = 0;
      do begin
         @(negedge Clock); #1;
         n++;
         done = (exp_q.size() == 0) && !OutValid;
      end while (!done && n < budget);
      check("drain", int'(done), 1);
      check("busy_after_drain", int'(Busy), 0);
   endtask

   // Output monitor.
   initial begin
      logic e;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            idx = 0;
            run_len = 0;
         end else if (OutValid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("data", int'(Output), int'(e));
               check("sym_start", int'(SymbolStart), int'(idx == 0));
               cap[idx] = Output;
               idx++;
               run_len++;
               valid_cnt++;
               if (len_q.size() > 0 && idx == len_q[0]) begin
                  void'(len_q.pop_front());
                  idx = 0;
               end
            end
         end else begin
            // Idle cycles: never inside a symbol, Output at its idle value.
            check("idle", int'({idx != 0, Output, SymbolStart}), 0);
            if (run_len != 0) last_run = run_len;
            run_len = 0;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] m;

      // Reset state.
      #2;
      check("rst_outputs", int'({Output, OutValid, SymbolStart, Busy}), 0);
      @(posedge Clock); @(posedge Clock); #1;
      Reset = 1'b0;
      @(posedge Clock); #1;

      // BPSK one-hot k=1, with latency and length checks.
      valid_cnt = 0;
      send_symbol(2'b00, one_hot(1), 1'b0, -1);
      check("busy_full", int'(Busy), 1);
      @(negedge Clock);
      check("lat_before", int'(OutValid), 0);
      @(negedge Clock);
      check("lat_first", int'({OutValid, SymbolStart}), 3);
      wait_drain(500);
      check("bpsk_onehot_k1", onehot_pos(48), 3);
      check("bpsk_valid_cnt", valid_cnt, 48);
      check("bpsk_run", last_run, 48);

      // QPSK and 16-QAM one-hots.
      send_symbol(2'b01, one_hot(1), 1'b0, -1);
      wait_drain(500);
      check("qpsk_onehot_k1", onehot_pos(96), 6);
      send_symbol(2'b01, one_hot(16), 1'b0, -1);
      wait_drain(500);
      check("qpsk_onehot_k16", onehot_pos(96), 1);
      send_symbol(2'b10, one_hot(1), 1'b0, -1);
      wait_drain(500);
      check("qam16_onehot_k1", onehot_pos(192), 13);
      send_symbol(2'b10, one_hot(16), 1'b0, -1);
      wait_drain(500);
      check("qam16_onehot_k16", onehot_pos(192), 1);

      // 64-QAM one-hot, then random data.
      send_symbol(2'b11, one_hot(1), 1'b0, -1);
      wait_drain(800);
      check("qam64_onehot_k1", onehot_pos(288), 20);
      send_symbol(2'b11, rand_bits(), 1'b0, -1);
      wait_drain(800);

      // Three continuous 64-QAM symbols: one unbroken 864-cycle burst.
      for (int s = 0; s < 3; s++) send_symbol(2'b11, rand_bits(), 1'b0, -1);
      wait_drain(1500);
      check("b2b_run", last_run, 864);

      // 50% duty input, same mode per group.
      for (int s = 0; s < 3; s++) send_symbol(2'b11, rand_bits(), 1'b1, -1);
      wait_drain(1500);
      for (int s = 0; s < 3; s++) send_symbol(2'b01, rand_bits(), 1'b1, -1);
      wait_drain(1500);

      // Random single symbols in random modes.
      for (int s = 0; s < 6; s++) begin
         m = 2'($urandom);
         send_symbol(m, rand_bits(), 1'($urandom), -1);
         wait_drain(1500);
      end

      // Reset mid-symbol while the previous symbol is streaming.
      send_symbol(2'b11, rand_bits(), 1'b0, -1);
      send_symbol(2'b01, rand_bits(), 1'b0, 60);
      check("pre_rst_busy", int'(Busy), 1);
      check("pre_rst_valid", int'(OutValid), 1);
      Reset = 1'b1;
      #1;
      check("rst_async", int'({OutValid, SymbolStart, Busy}), 0);
      exp_q.delete();
      len_q.delete();
      idx = 0;
      @(posedge Clock); @(posedge Clock); #1;
      Reset = 1'b0;
      repeat (20) @(posedge Clock);
      #1;
      send_symbol(2'b01, rand_bits(), 1'b0, -1);
      @(negedge Clock);
      check("post_rst_lat_before", int'(OutValid), 0);
      @(negedge Clock);
      check("post_rst_first", int'({OutValid, SymbolStart}), 3);
      wait_drain(500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
